qea_host_sequencer: RTL and testbench
=====================================

// Module: qea_host_sequencer
// PURPOSE
// Host-side sequencer directly upstream of QEA; automates the QEA load/run/readback protocol in hardware.
// Streams gate-context words into QEA ctx RAM, then initialises state RAM to |0...0>.
// Pulses start, waits for complete, then streams final state words out on a valid/ready port.
// PARAMETERS
// PE_NUM_WIDTH 2 - log2(PE_NUM)
// PE_NUM 4 - amplitude lanes per state word
// DATA_WIDTH 32 - fixed-point component width
// MAX_QBIT_WIDTH 6 - width of qubit-count field
// STATE_DATA_WIDTH 64 - one complex amplitude, {re,im}
// STATE_ADDR_WIDTH 16 - state RAM address width
// GATE_CONTEXT_DATA_WIDTH 64 - ctx word width
// GATE_CONTEXT_ADDR_WIDTH 16 - ctx RAM address width
// NUM_FRAC_BIT 30 - fraction bits; amplitude 1.0 = 1<<NUM_FRAC_BIT
// RD_LATENCY 1 - QEA o_state_dout latency after address, cycles (1..4)
// PORTS
// clk in 1 - clock
// rst in 1 - synchronous active-high reset
// i_cfg_start in 1 - start a full job (pulse)
// i_qbit_num in MAX_QBIT_WIDTH - qubits for this job, latched at i_cfg_start
// i_ins_num in GATE_CONTEXT_ADDR_WIDTH - ctx words to load, latched at i_cfg_start
// s_ctx_valid/s_ctx_ready in/out 1 - ctx input handshake
// s_ctx_data in GATE_CONTEXT_DATA_WIDTH - ctx word
// o_ctx_en,o_ctx_wea out 1 - to QEA i_ctx_en/i_ctx_wea
// o_ctx_addr out GATE_CONTEXT_ADDR_WIDTH; o_ctx_data out GATE_CONTEXT_DATA_WIDTH
// o_state_ena,o_state_wea out 1; o_state_addra out STATE_ADDR_WIDTH; o_state_dina out PE_NUM*STATE_DATA_WIDTH
// o_qea_start out 1 - to QEA i_start; i_qea_complete in 1 - from QEA o_complete
// i_state_dout in PE_NUM*STATE_DATA_WIDTH - from QEA o_state_dout
// m_out_valid/m_out_ready out/in 1; m_out_data out PE_NUM*STATE_DATA_WIDTH - readback stream
// o_busy out 1; o_done out 1 (1-cycle pulse); o_err out 1 (1-cycle pulse)
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, counters 0; rst mid-job aborts at once, no further QEA writes.
// - FSM: IDLE->LOAD_CTX->INIT_STATE->START->RUN->RD_ISSUE->RD_WAIT->RD_HOLD->(RD_ISSUE|DONE)->IDLE.
// - IDLE: i_cfg_start latches qbit/ins; N = 2**(qbit_num-PE_NUM_WIDTH) state words.
// - Reject if ins_num==0, qbit_num<PE_NUM_WIDTH or qbit_num>STATE_ADDR_WIDTH+PE_NUM_WIDTH: o_err 1 cycle, stay IDLE.
// - i_cfg_start ignored while o_busy=1 (all states except IDLE).
// - LOAD_CTX: s_ctx_ready=1; per accepted beat drive en=wea=1, addr=k (0..ins_num-1), data registered next cycle.
//   Gaps in s_ctx_valid drop en/wea that cycle; after beat ins_num-1 ready drops, go INIT_STATE.
// - INIT_STATE: one write per cycle, addr 0..N-1, ena=wea=1; addr 0 dina = top lane re = 1<<NUM_FRAC_BIT, rest 0; others 0.
// - START: o_qea_start=1 exactly one cycle. RUN: i_qea_complete ignored on first RUN cycle, then sampled; 1 -> RD_ISSUE.
// - RD_ISSUE: ena=1, wea=0 (never write during readback), addr=j. RD_WAIT: RD_LATENCY cycles, then capture i_state_dout.
// - RD_HOLD: m_out_valid=1, m_out_data stable until m_out_ready; on handshake j++; j==N-1 -> DONE.
// - DONE: o_done=1 one cycle -> IDLE. Address counters sized STATE_ADDR_WIDTH+1 so N=2**STATE_ADDR_WIDTH terminates.
// - Word order to m_out: address ascending, lane layout identical to QEA o_state_dout.
// CONFIGURATION
// HOST_CYCLE_COUNT_EN defined: adds output o_exec_cycles [31:0], reset 0, cleared in START, +1 each RUN cycle
//   (saturates at 32'hFFFFFFFF), held after RUN until next job. Undefined: port absent, no counter logic.
// TESTING
// - qbit=4,ins=3, ctx 3 beats back-to-back -> ctx writes addr 0,1,2 data match; state writes addr 0..3, addr0 top re=32'h40000000.
// - s_ctx_valid toggling 1/0 for 5 words -> exactly 5 ctx writes, addrs contiguous 0..4, no write on gaps.
// - QEA model asserts complete 10 cycles after start -> exactly one o_qea_start pulse; readback of 4 words ascending; o_done once.
// - m_out_ready low 7 cycles in RD_HOLD -> m_out_data stable, no extra state reads, wea=0 throughout readback.
// - qbit=1 or ins=0 -> o_err pulse, zero QEA writes; rst asserted mid INIT_STATE -> all outputs 0 next cycle, FSM IDLE.
// - HOST_CYCLE_COUNT_EN, complete after 10 RUN cycles -> o_exec_cycles=10; i_cfg_start while busy ignored.

Source files
------------

// File: rtl/qea_host_sequencer_if.sv
// qea_host_sequencer_if: host/QEA bus bundle for the sequencer; carries o_exec_cycles when HOST_CYCLE_COUNT_EN is defined
interface qea_host_sequencer_if #(
  parameter int PE_NUM                  = 4,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16
);
  localparam int WW = PE_NUM * STATE_DATA_WIDTH;
  logic                               i_cfg_start;
  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] i_ins_num;
  logic                               s_ctx_valid;
  logic                               s_ctx_ready;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] s_ctx_data;
  logic                               o_ctx_en;
  logic                               o_ctx_wea;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] o_ctx_addr;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] o_ctx_data;
  logic                               o_state_ena;
  logic                               o_state_wea;
  logic [STATE_ADDR_WIDTH-1:0]        o_state_addra;
  logic [WW-1:0]                      o_state_dina;
  logic                               o_qea_start;
  logic                               i_qea_complete;
  logic [WW-1:0]                      i_state_dout;
  logic                               m_out_valid;
  logic                               m_out_ready;
  logic [WW-1:0]                      m_out_data;
  logic                               o_busy;
  logic                               o_done;
  logic                               o_err;
`ifdef HOST_CYCLE_COUNT_EN
  logic [31:0]                        o_exec_cycles;
`endif
  modport master (
    input  i_cfg_start, i_qbit_num, i_ins_num, s_ctx_valid, s_ctx_data,
    input  i_qea_complete, i_state_dout, m_out_ready,
    output s_ctx_ready, o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data,
    output o_state_ena, o_state_wea, o_state_addra, o_state_dina,
    output o_qea_start, m_out_valid, m_out_data, o_busy, o_done, o_err
`ifdef HOST_CYCLE_COUNT_EN
    , output o_exec_cycles
`endif
  );
  modport slave (
    output i_cfg_start, i_qbit_num, i_ins_num, s_ctx_valid, s_ctx_data,
    output i_qea_complete, i_state_dout, m_out_ready,
    input  s_ctx_ready, o_ctx_en, o_ctx_wea, o_ctx_addr, o_ctx_data,
    input  o_state_ena, o_state_wea, o_state_addra, o_state_dina,
    input  o_qea_start, m_out_valid, m_out_data, o_busy, o_done, o_err
`ifdef HOST_CYCLE_COUNT_EN
    , input o_exec_cycles
`endif
  );
endinterface

// File: rtl/qea_host_sequencer.sv
// qea_host_sequencer: QEA load/init/run/readback automation; HOST_CYCLE_COUNT_EN adds the o_exec_cycles run counter
module qea_host_sequencer #(
  parameter int PE_NUM_WIDTH            = 2,
  parameter int PE_NUM                  = 4,
  parameter int DATA_WIDTH              = 32,
  parameter int MAX_QBIT_WIDTH          = 6,
  parameter int STATE_DATA_WIDTH        = 64,
  parameter int STATE_ADDR_WIDTH        = 16,
  parameter int GATE_CONTEXT_DATA_WIDTH = 64,
  parameter int GATE_CONTEXT_ADDR_WIDTH = 16,
  parameter int NUM_FRAC_BIT            = 30,
  parameter int RD_LATENCY              = 1
) (
  input logic clk,
  input logic rst,
  qea_host_sequencer_if.master bus
);
  localparam int WW = PE_NUM * STATE_DATA_WIDTH;
  localparam int AW = STATE_ADDR_WIDTH + 1;
  localparam logic [WW-1:0] INIT_WORD = WW'(1) << (WW - DATA_WIDTH + NUM_FRAC_BIT);
  localparam logic [MAX_QBIT_WIDTH-1:0] QMIN = MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
  localparam logic [MAX_QBIT_WIDTH-1:0] QMAX = MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH + PE_NUM_WIDTH);
  typedef enum logic [3:0] {IDLE, LOAD_CTX, INIT_STATE, START, RUN, RD_ISSUE, RD_WAIT, RD_HOLD, DONE} state_t;
  state_t                             r_state, w_next;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] r_ins, r_k;
  logic [GATE_CONTEXT_ADDR_WIDTH-1:0] r_ctx_addr;
  logic [GATE_CONTEXT_DATA_WIDTH-1:0] r_ctx_data;
  logic [AW-1:0]                      r_n, r_j;
  logic [2:0]                         r_lat;
  logic [WW-1:0]                      r_data;
  logic                               r_ctx_en, r_first, r_err;
  logic                               w_cfg_ok, w_ctx_hs, w_last, w_rd_done;
  logic [MAX_QBIT_WIDTH-1:0]          w_shift;
  assign w_cfg_ok  = bus.i_ins_num != '0 && bus.i_qbit_num >= QMIN && bus.i_qbit_num <= QMAX;
  assign w_shift   = bus.i_qbit_num - QMIN;
  assign w_ctx_hs  = r_state == LOAD_CTX && bus.s_ctx_valid;
  assign w_last    = r_j == r_n - 1'b1;
  assign w_rd_done = r_state == RD_WAIT && r_lat == 3'(RD_LATENCY - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:       w_next = bus.i_cfg_start && w_cfg_ok ? LOAD_CTX : IDLE;
      LOAD_CTX:   w_next = w_ctx_hs && r_k == r_ins - 1'b1 ? INIT_STATE : LOAD_CTX;
      INIT_STATE: w_next = w_last ? START : INIT_STATE;
      START:      w_next = RUN;
      RUN:        w_next = !r_first && bus.i_qea_complete ? RD_ISSUE : RUN;
      RD_ISSUE:   w_next = RD_WAIT;
      RD_WAIT:    w_next = w_rd_done ? RD_HOLD : RD_WAIT;
      RD_HOLD:    w_next = !bus.m_out_ready ? RD_HOLD : w_last ? DONE : RD_ISSUE;
      default:    w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ins      <= '0;
      r_k        <= '0;
      r_n        <= '0;
      r_j        <= '0;
      r_lat      <= '0;
      r_data     <= '0;
      r_ctx_en   <= 1'b0;
      r_ctx_addr <= '0;
      r_ctx_data <= '0;
      r_first    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_err    <= r_state == IDLE && bus.i_cfg_start && !w_cfg_ok;
      r_ctx_en <= w_ctx_hs;
      r_first  <= r_state == START;
      r_lat    <= r_state == RD_WAIT ? r_lat + 1'b1 : '0;
      if (r_state == IDLE && bus.i_cfg_start) begin
        r_ins <= bus.i_ins_num;
        r_n   <= AW'(1) << w_shift;
        r_k   <= '0;
        r_j   <= '0;
      end
      if (w_ctx_hs) begin
        r_ctx_addr <= r_k;
        r_ctx_data <= bus.s_ctx_data;
        r_k        <= r_k + 1'b1;
      end
      // j is reused: init write address, then rewound to 0 for readback
      if (r_state == INIT_STATE) r_j <= w_last ? '0 : r_j + 1'b1;
      if (r_state == RD_HOLD && bus.m_out_ready) r_j <= r_j + 1'b1;
      if (w_rd_done) r_data <= bus.i_state_dout;
    end
  end
`ifdef HOST_CYCLE_COUNT_EN
  logic [31:0] r_cyc;
  always_ff @(posedge clk) begin
    if (rst) r_cyc <= '0;
    else if (r_state == START) r_cyc <= '0;
    else if (r_state == RUN && r_cyc != '1) r_cyc <= r_cyc + 1'b1;
  end
  assign bus.o_exec_cycles = r_cyc;
`endif
  assign bus.s_ctx_ready   = r_state == LOAD_CTX;
  assign bus.o_ctx_en      = r_ctx_en;
  assign bus.o_ctx_wea     = r_ctx_en;
  assign bus.o_ctx_addr    = r_ctx_addr;
  assign bus.o_ctx_data    = r_ctx_data;
  assign bus.o_state_ena   = r_state == INIT_STATE || r_state == RD_ISSUE;
  assign bus.o_state_wea   = r_state == INIT_STATE;
  assign bus.o_state_addra = r_j[STATE_ADDR_WIDTH-1:0];
  assign bus.o_state_dina  = r_state == INIT_STATE && r_j == '0 ? INIT_WORD : '0;
  assign bus.o_qea_start   = r_state == START;
  assign bus.m_out_valid   = r_state == RD_HOLD;
  assign bus.m_out_data    = r_data;
  assign bus.o_busy        = r_state != IDLE;
  assign bus.o_done        = r_state == DONE;
  assign bus.o_err         = r_err;
endmodule

// File: tb/tb_qea_host_sequencer.sv
// tb_qea_host_sequencer: randomized jobs against a QEA memory model and expected-result lists
module tb_qea_host_sequencer;
  localparam logic [255:0] ONE = {32'h40000000, 224'd0};
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  qea_host_sequencer_if bus ();
  qea_host_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
  int checks = 0, errors = 0;
  logic [63:0]  words[$];
  logic [15:0]  ctx_a_q[$], st_a_q[$], rd_a_q[$];
  logic [63:0]  ctx_d_q[$];
  logic [255:0] st_d_q[$], exp_q[$], out_q[$];
  logic [255:0] mem [int];
  int n_start, n_done, n_err, n_bad, n_late, run_d, run_left, cur_n, stall_left;
  bit started, stall_arm, rd_pend, hold_v;
  logic [15:0]  rd_addr;
  logic [255:0] hold_prev;

  task automatic chk(string tag, logic [255:0] got, logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // QEA model and readback consumer, all observed mid-cycle
  initial begin
    bus.i_qea_complete = 1'b0;
    bus.m_out_ready = 1'b0;
    forever begin
      @(negedge clk);
      bus.i_qea_complete = 1'b0;
      if (rst) run_left = 0;
      if (bus.o_ctx_en) begin
        ctx_a_q.push_back(bus.o_ctx_addr);
        ctx_d_q.push_back(bus.o_ctx_data);
        if (!bus.o_ctx_wea) n_bad++;
      end
      if (bus.o_state_ena && bus.o_state_wea) begin
        st_a_q.push_back(bus.o_state_addra);
        st_d_q.push_back(bus.o_state_dina);
        mem[int'(bus.o_state_addra)] = bus.o_state_dina;
        if (started) n_late++;
      end
      if (bus.o_state_ena && !bus.o_state_wea) begin
        rd_a_q.push_back(bus.o_state_addra);
        rd_pend = 1'b1;
        rd_addr = bus.o_state_addra;
      end
      if (run_left > 0) begin
        run_left--;
        if (run_left == 0) bus.i_qea_complete = 1'b1;
      end
      if (bus.o_qea_start) begin
        n_start++;
        started = 1'b1;
        run_left = run_d;
        for (int i = 0; i < cur_n; i++) begin
          mem[i] = rnd256();
          exp_q.push_back(mem[i]);
        end
      end
      if (bus.o_done) n_done++;
      if (bus.o_err) n_err++;
      if (bus.m_out_valid && stall_arm) begin
        stall_left = 7;
        stall_arm = 1'b0;
      end
      bus.m_out_ready = stall_left > 0 ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (stall_left > 0) stall_left--;
      if (bus.m_out_valid) begin
        if (hold_v) chk("hold_stable", bus.m_out_data, hold_prev);
        hold_prev = bus.m_out_data;
        hold_v = !bus.m_out_ready;
        if (bus.m_out_ready) out_q.push_back(bus.m_out_data);
      end else hold_v = 1'b0;
    end
  end

  // one-cycle read latency: data valid only in the cycle after the address
  initial forever begin
    @(posedge clk);
    #1;
    bus.i_state_dout = rd_pend ? mem[int'(rd_addr)] : rnd256();
    rd_pend = 1'b0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic clear();
    ctx_a_q.delete(); ctx_d_q.delete(); st_a_q.delete(); st_d_q.delete();
    rd_a_q.delete(); exp_q.delete(); out_q.delete(); words.delete();
    n_start = 0; n_done = 0; n_err = 0; n_bad = 0; n_late = 0;
    started = 1'b0;
  endtask

  task automatic pulse_cfg(int q, int n);
    @(negedge clk);
    bus.i_cfg_start = 1'b1;
    bus.i_qbit_num = 6'(q);
    bus.i_ins_num = 16'(n);
    @(negedge clk);
    bus.i_cfg_start = 1'b0;
  endtask

  task automatic feed_ctx(int n, bit gaps);
    int w;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        bus.s_ctx_valid = 1'b0;
        @(negedge clk);
      end
      bus.s_ctx_valid = 1'b1;
      bus.s_ctx_data = words[i];
      w = 0;
      while (!bus.s_ctx_ready && w < 50) begin
        @(negedge clk);
        w++;
      end
      if (w >= 50) begin
        chk("ctx_ready_timeout", 0, 1);
        break;
      end
      @(negedge clk);
    end
    bus.s_ctx_valid = 1'b0;
  endtask

  task automatic run_job(int qbit, int ins, bit gaps, bit stall, int rdd, bit poke);
    int w;
    clear();
    cur_n = 1 << (qbit - 2);
    run_d = rdd;
    stall_arm = stall;
    for (int i = 0; i < ins; i++) words.push_back({$urandom, $urandom});
    pulse_cfg(qbit, ins);
    feed_ctx(ins, gaps);
    if (poke) begin
      w = 0;
      while (n_start == 0 && w < 2000) begin
        @(negedge clk);
        w++;
      end
      pulse_cfg(6, 2);
    end
    w = 0;
    while (n_done == 0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    chk("ctx_cnt", ctx_a_q.size(), ins);
    for (int i = 0; i < ctx_a_q.size() && i < ins; i++) begin
      chk("ctx_addr", ctx_a_q[i], i);
      chk("ctx_data", ctx_d_q[i], words[i]);
    end
    chk("ctx_wea", n_bad, 0);
    chk("st_cnt", st_a_q.size(), cur_n);
    for (int i = 0; i < st_a_q.size() && i < cur_n; i++) begin
      chk("st_addr", st_a_q[i], i);
      chk("st_data", st_d_q[i], i == 0 ? ONE : 256'd0);
    end
    chk("start_cnt", n_start, 1);
    chk("write_in_readback", n_late, 0);
    chk("rd_cnt", rd_a_q.size(), cur_n);
    for (int i = 0; i < rd_a_q.size() && i < cur_n; i++) chk("rd_addr", rd_a_q[i], i);
    chk("out_cnt", out_q.size(), cur_n);
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) chk("out_data", out_q[i], exp_q[i]);
    chk("done_cnt", n_done, 1);
    chk("err_cnt", n_err, 0);
    chk("busy_after", bus.o_busy, 0);
`ifdef HOST_CYCLE_COUNT_EN
    chk("exec_cycles", bus.o_exec_cycles, rdd);
`endif
  endtask

  task automatic reject(int qbit, int ins);
    clear();
    pulse_cfg(qbit, ins);
    repeat (5) @(negedge clk);
    chk("err_pulse", n_err, 1);
    chk("err_busy", bus.o_busy, 0);
    chk("err_ctx_wr", ctx_a_q.size(), 0);
    chk("err_st_wr", st_a_q.size(), 0);
  endtask

  task automatic reset_mid_init();
    int w, n;
    clear();
    cur_n = 16;
    run_d = 5;
    for (int i = 0; i < 2; i++) words.push_back({$urandom, $urandom});
    pulse_cfg(6, 2);
    feed_ctx(2, 0);
    w = 0;
    while (st_a_q.size() < 3 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("rst_reach_init", st_a_q.size() >= 3, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_outs", {bus.o_busy, bus.o_ctx_en, bus.o_ctx_wea, bus.o_state_ena, bus.o_state_wea,
                     bus.o_qea_start, bus.m_out_valid, bus.s_ctx_ready, bus.o_done, bus.o_err}, 0);
    chk("rst_addr", {bus.o_state_addra, bus.o_ctx_addr}, 0);
    chk("rst_data", bus.m_out_data | bus.o_state_dina | bus.o_ctx_data, 0);
    @(negedge clk);
    rst = 1'b0;
    n = st_a_q.size();
    repeat (20) @(negedge clk);
    chk("rst_no_writes", st_a_q.size(), n);
    chk("rst_idle", bus.o_busy, 0);
    chk("rst_no_start", n_start, 0);
  endtask

  initial begin
    bus.i_cfg_start = 1'b0;
    bus.i_qbit_num = '0;
    bus.i_ins_num = '0;
    bus.s_ctx_valid = 1'b0;
    bus.s_ctx_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {bus.o_busy, bus.o_ctx_en, bus.o_state_ena, bus.o_qea_start,
                       bus.m_out_valid, bus.s_ctx_ready, bus.o_done, bus.o_err}, 0);
    chk("reset_data", bus.m_out_data, 0);
`ifdef HOST_CYCLE_COUNT_EN
    chk("reset_exec", bus.o_exec_cycles, 0);
`endif
    rst = 1'b0;
    run_job(4, 3, 0, 0, 10, 0);
    run_job(4, 5, 1, 1, 10, 0);
    run_job(2, 1, 0, 0, 2, 0);
    run_job(3, 4, 0, 0, 30, 1);
    reject(1, 3);
    reject(4, 0);
    reject(19, 2);
    reject(0, 1);
    reset_mid_init();
    for (int i = 0; i < 6; i++)
      run_job($urandom_range(2, 6), $urandom_range(1, 8), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom_range(2, 20), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
